instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader.sv | 180 ++++++++++++++++++
 tb/tb_instr_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Serial program loader: receives a word count and big-endian instruction bytes, writes a 64-word imem.
// Optional trailing checksum byte enabled by defining LOADER_CHECKSUM_EN.
module instr_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [5:0]  imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        BYTES = 3'd2,
        WRITE = 3'd3,
`ifdef LOADER_CHECKSUM_EN
        CHECK = 3'd4,
`endif
        DONE  = 3'd5,
        ERROR = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  count_q, count_d;
    logic [6:0]  idx_q, idx_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [23:0] word_q, word_d;
    logic [5:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [6:0]  idx_inc;
    logic        accept;
    state_t      load_end;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
    logic [7:0]  sum_chk;

    assign sum_chk  = sum_q + rx_data;
    assign load_end = CHECK;
`else
    assign load_end = DONE;
`endif

    assign accept  = rx_valid && rx_ready;
    assign idx_inc = idx_q + 7'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = COUNT;
            end
            COUNT: begin
                if (accept) begin
                    if (rx_data == 8'd0)       state_d = load_end;
                    else if (rx_data > 8'd64)  state_d = ERROR;
                    else                       state_d = BYTES;
                end
            end
            BYTES: begin
                if (accept && bcnt_q == 2'd3) state_d = WRITE;
            end
            WRITE: begin
                state_d = (idx_inc == count_q) ? load_end : BYTES;
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (accept) state_d = (sum_chk == 8'h00) ? DONE : ERROR;
            end
`endif
            DONE, ERROR: begin
                if (start) state_d = COUNT;
            end
            default: state_d = IDLE;
        endcase
    end

    // Word is assembled in a 24-bit shifter; the 4th byte completes it straight into the write register,
    // so imem_wdata only changes when a new word is ready and holds otherwise.
    always_comb begin
        count_d = count_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        word_d  = word_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        if (state_q == COUNT && accept) begin
            count_d = rx_data[6:0];
            idx_d   = '0;
            bcnt_d  = '0;
`ifdef LOADER_CHECKSUM_EN
            sum_d   = '0;
`endif
        end
        if (state_q == BYTES && accept) begin
            word_d = {word_q[15:0], rx_data};
            bcnt_d = bcnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            sum_d  = sum_q + rx_data;
`endif
            if (bcnt_q == 2'd3) begin
                addr_d  = idx_q[5:0];
                wdata_d = {word_q, rx_data};
            end
        end
        if (state_q == WRITE) begin
            idx_d = idx_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            word_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            count_q <= count_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // Write strobe is masked by reset so a reset landing on a WRITE cycle commits nothing.
    always_comb begin
        rx_ready   = 1'b0;
        busy       = 1'b0;
        imem_we    = (state_q == WRITE) && !reset;
        done       = (state_q == DONE);
        err        = (state_q == ERROR);
        cpu_reset  = (state_q != DONE);
        imem_addr  = addr_q;
        imem_wdata = wdata_q;
        case (state_q)
            COUNT, BYTES: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
            WRITE: busy = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: loads push expected imem writes, a monitor pops and compares them.
// Checksum scenarios are included when LOADER_CHECKSUM_EN is defined.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];

    instr_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        rx_valid = 1'b0;
        repeat (gap) step();
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        while (!rx_ready && t < 50) begin
            step();
            t++;
        end
        if (!rx_ready) check("rx_ready_timeout", rx_ready, 1);
        step();
        rx_valid = 1'b0;
    endtask

    // Reference: every data word goes to consecutive addresses from 0; the load ends in DONE unless
    // the count exceeds 64 or (with checksum) the data bytes plus checksum byte do not sum to zero.
    task automatic load(input int n, input int gap, input bit rand_gap, input bit bad_sum,
                        input bit mid_start, input logic [31:0] w0, input bit use_w0);
        logic [31:0] w;
        logic [7:0]  b;
        logic [7:0]  sum;
        bit          exp_ok;
        int          t;
        wr_t         e;
        logic [7:0]  nb;
        nb = n[7:0];
        pulse_start();
        check("busy_in_count", busy, 1);
        check("cpu_reset_in_count", cpu_reset, 1);
        send_byte(nb, 0);
        sum = 8'h00;
        if (n > 64) begin
            check("err_on_overflow", err, 1);
            check("cpu_reset_on_overflow", cpu_reset, 1);
            check("busy_on_overflow", busy, 0);
            check("done_on_overflow", done, 0);
            return;
        end
        for (int i = 0; i < n; i++) begin
            w = (use_w0 && i == 0) ? w0 : $urandom;
            e.addr = i[5:0];
            e.data = w;
            exp_q.push_back(e);
            for (int k = 0; k < 4; k++) begin
                b = w[31-8*k -: 8];
                sum = sum + b;
                send_byte(b, rand_gap ? int'($urandom_range(0, 2)) : gap);
                if (mid_start && i == 0 && k == 1) begin
                    pulse_start();
                    check("start_ignored_busy", busy, 1);
                    check("start_ignored_ready", rx_ready, 1);
                end
            end
            check("we_after_word", imem_we, 1);
        end
`ifdef LOADER_CHECKSUM_EN
        b = 8'h00 - sum;
        if (bad_sum) b = b + 8'd1;
        send_byte(b, 0);
        exp_ok = !bad_sum;
`else
        if (n > 0) step();
        exp_ok = 1'b1;
`endif
        t = 0;
        while (!(done || err) && t < 20) begin
            step();
            t++;
        end
        check("load_done_timing_or_value", done, exp_ok);
        check("load_err", err, !exp_ok);
        check("load_cpu_reset", cpu_reset, !exp_ok);
        check("load_busy", busy, 0);
        check("load_end_latency", t, 0);
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (imem_we === 1'b1) begin
            check("rx_ready_in_write", rx_ready, 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data %h with nothing expected", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", imem_addr, e.addr);
                check("write_data", imem_wdata, e.data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        wr_t e;
        logic [31:0] w;
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) step();
        check("rst_rx_ready", rx_ready, 0);
        check("rst_imem_we", imem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_imem_wdata", imem_wdata, 0);
        reset = 1'b0;
        step();

        // single word, no gaps
        load(1, 0, 0, 0, 0, 32'h20080005, 1);
        // three words with rx_valid every other cycle
        load(3, 1, 0, 0, 0, 32'h0, 0);
        // count 65 aborts
        load(65, 0, 0, 0, 0, 32'h0, 0);

        // reset after 2 bytes of word 1
        pulse_start();
        send_byte(8'd2, 0);
        w = $urandom;
        e.addr = 6'd0;
        e.data = w;
        exp_q.push_back(e);
        for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], 0);
        send_byte(8'hAA, 0);
        send_byte(8'h55, 0);
        reset = 1'b1;
        step();
        check("abort_busy", busy, 0);
        check("abort_cpu_reset", cpu_reset, 1);
        check("abort_rx_ready", rx_ready, 0);
        check("abort_imem_addr", imem_addr, 0);
        reset = 1'b0;
        step();
        check("abort_idle_done", done, 0);

        // start pulsed mid-load is ignored, then restart from DONE
        load(2, 0, 0, 0, 1, 32'h0, 0);
        pulse_start();
        check("restart_cpu_reset", cpu_reset, 1);
        check("restart_done", done, 0);
        check("restart_busy", busy, 1);
        load(1, 0, 0, 0, 0, 32'hCAFEF00D, 1);

        // boundaries
        load(0, 0, 0, 0, 0, 32'h0, 0);
        load(64, 0, 1, 0, 0, 32'h0, 0);

`ifdef LOADER_CHECKSUM_EN
        load(1, 0, 0, 0, 0, 32'h01020304, 1);
        load(1, 0, 0, 1, 0, 32'h01020304, 1);
`endif

        repeat (6) begin
            load(int'($urandom_range(1, 8)), 0, 1, bit'($urandom_range(0, 1)), 0, 32'h0, 0);
        end

        repeat (3) step();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
